// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, sequencer state encoding and next-PC helper.
package cpu_pkg;

   localparam int unsigned INSTR_W = 18;
   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned TOUT_W  = 8;

   // Sequencer states; the encoding is exported on o_state for debug
   typedef enum logic [STATE_W-1:0] {
      ST_RESET = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_HALT  = 3'd3,
      ST_FAULT = 3'd4
   } seq_state_t;

   // Branch outcome delivered by the control unit at commit
   typedef struct packed {
      logic              taken;
      logic [ADDR_W-1:0] target;
   } branch_t;

   // Next PC after a committed instruction; sequential flow wraps at 2^ADDR_W
   function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc,
                                                 input branch_t           br);
      return br.taken ? br.target : pc + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter register with next-PC selection (jump target or PC+1).
module pc_unit
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              commit,
   input  branch_t           branch,
   output logic [ADDR_W-1:0] pc
);

   // PC moves only when an instruction commits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (commit) begin
         pc <= pc_next(pc, branch);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/execute sequencer with fetch timeout fault and halt control.
// Optional feature: define SEQ_SINGLE_STEP_EN to add the i_step single-step port.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
   parameter logic [TOUT_W-1:0] TIMEOUT  = 8'd255
) (
   input  logic                i_clk,
   input  logic                i_rst,
   output logic [ADDR_W-1:0]   o_imem_addr,
   output logic                o_imem_req,
   input  logic                i_imem_ack,
   input  logic [INSTR_W-1:0]  i_imem_data,
   output logic [INSTR_W-1:0]  o_instruction,
   output logic                o_exec,
   input  logic                i_jump_taken,
   input  logic [ADDR_W-1:0]   i_jump_target,
   input  logic                i_stk_busy,
   input  logic                i_halt,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                i_step,
`endif
   output logic                o_halted,
   output logic                o_fault,
   output logic [STATE_W-1:0]  o_state
);

   seq_state_t        state;
   logic [TOUT_W-1:0] tcount;
   logic              commit;
   logic              timeout_hit;
   logic              halt_on_commit;
   logic              leave_halt;
   branch_t           branch;

   // Commit strobe is combinational so a stack stall blocks writes in the same cycle
   assign commit      = (state == ST_EXEC) && !i_stk_busy;
   assign o_exec      = commit;
   assign timeout_hit = (tcount + TOUT_W'(1)) == TIMEOUT;
   assign branch      = {i_jump_taken, i_jump_target};
   assign o_state     = state;

`ifdef SEQ_SINGLE_STEP_EN
   logic stepping;

   // A single step forces a return to HALT once its instruction commits
   assign halt_on_commit = i_halt || stepping;
   assign leave_halt     = i_step || !i_halt;

   // Remember that the current instruction was launched by a step pulse
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         stepping <= 1'b0;
      end else if ((state == ST_HALT) && i_step) begin
         stepping <= 1'b1;
      end else if (commit) begin
         stepping <= 1'b0;
      end
   end
`else
   assign halt_on_commit = i_halt;
   assign leave_halt     = !i_halt;
`endif

   // Sequencer FSM with registered request/halted/fault flags
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= ST_RESET;
         o_imem_req <= 1'b0;
         o_halted   <= 1'b0;
         o_fault    <= 1'b0;
      end else begin
         case (state)
            ST_RESET: begin
               state      <= ST_FETCH;
               o_imem_req <= 1'b1;
            end
            ST_FETCH: begin
               if (i_imem_ack) begin
                  state      <= ST_EXEC;
                  o_imem_req <= 1'b0;
               end else if (timeout_hit) begin
                  state      <= ST_FAULT;
                  o_imem_req <= 1'b0;
                  o_fault    <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (commit) begin
                  if (halt_on_commit) begin
                     state    <= ST_HALT;
                     o_halted <= 1'b1;
                  end else begin
                     state      <= ST_FETCH;
                     o_imem_req <= 1'b1;
                  end
               end
            end
            ST_HALT: begin
               if (leave_halt) begin
                  state      <= ST_FETCH;
                  o_halted   <= 1'b0;
                  o_imem_req <= 1'b1;
               end
            end
            ST_FAULT: begin
               state <= ST_FAULT;
            end
            default: begin
               state      <= ST_FAULT;
               o_imem_req <= 1'b0;
               o_halted   <= 1'b0;
               o_fault    <= 1'b1;
            end
         endcase
      end
   end

   // Count unacknowledged fetch cycles; cleared when an instruction arrives
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tcount <= '0;
      end else if (state == ST_FETCH) begin
         if (i_imem_ack) begin
            tcount <= '0;
         end else begin
            tcount <= tcount + TOUT_W'(1);
         end
      end
   end

   // Instruction register captures the word returned with the acknowledge
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_instruction <= '0;
      end else if ((state == ST_FETCH) && i_imem_ack) begin
         o_instruction <= i_imem_data;
      end
   end

   pc_unit #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk    (i_clk),
      .rst    (i_rst),
      .commit (commit),
      .branch (branch),
      .pc     (o_imem_addr)
   );

endmodule
